// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// mem_ctrl_if : fetch / load-store request ports and byte-RAM port of mem_ctrl
// Revision    : 1.0
// ============================================================================
interface mem_ctrl_if;
    logic        rdy_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_inst_out;
    logic        mem_req_in;
    logic        mem_we_in;
    logic [1:0]  mem_len_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_wdata_in;
    logic        mem_done_out;
    logic [31:0] mem_rdata_out;
    logic [7:0]  ram_din_in;
    logic [7:0]  ram_dout_out;
    logic [31:0] ram_a_out;
    logic        ram_wr_out;

    modport slave (
        input  rdy_in, if_req_in, if_addr_in, mem_req_in, mem_we_in,
               mem_len_in, mem_addr_in, mem_wdata_in, ram_din_in,
        output if_done_out, if_inst_out, mem_done_out, mem_rdata_out,
               ram_dout_out, ram_a_out, ram_wr_out
    );

    modport master (
        output rdy_in, if_req_in, if_addr_in, mem_req_in, mem_we_in,
               mem_len_in, mem_addr_in, mem_wdata_in, ram_din_in,
        input  if_done_out, if_inst_out, mem_done_out, mem_rdata_out,
               ram_dout_out, ram_a_out, ram_wr_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : arbitrates fetch and load/store requests onto a byte-wide RAM
// Revision : 1.0
// ============================================================================
module mem_ctrl (
    input  wire logic  clk_in,
    input  wire logic  rst_in,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_RD  = 2'd1,
        ST_MEM_RD = 2'd2,
        ST_MEM_WR = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_len;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_ram_a;
    logic [7:0]  r_ram_dout;
    logic        r_wstrobe;
    logic        r_if_done;
    logic        r_mem_done;
    logic [31:0] r_if_inst;
    logic [31:0] r_mem_rdata;

    logic [2:0]  w_mem_len;
    logic [2:0]  w_next_cnt;
    logic        w_last;
    logic        w_grant_ok;
    logic [31:0] w_buf_next;
    logic [31:0] w_next_a;
    logic [7:0]  w_wr_byte;

    always_comb begin
        case (bus.mem_len_in)
            2'b00:   w_mem_len = 3'd1;
            2'b01:   w_mem_len = 3'd2;
            default: w_mem_len = 3'd4;
        endcase
    end

    assign w_next_cnt = r_cnt + 3'd1;
    assign w_last     = (w_next_cnt == r_len);
    assign w_grant_ok = !r_if_done && !r_mem_done;
    assign w_next_a   = r_base + {29'd0, w_next_cnt};
    assign w_buf_next = r_buf | ({24'd0, bus.ram_din_in} << {r_cnt[1:0], 3'b000});
    assign w_wr_byte  = r_wdata[{w_next_cnt[1:0], 3'b000} +: 8];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_base      <= 32'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_ram_a     <= 32'd0;
            r_ram_dout  <= 8'd0;
            r_wstrobe   <= 1'b0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            // Done flags clear even when paused so each completion is one pulse
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            if (bus.rdy_in) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_grant_ok) begin
                            r_cnt <= 3'd0;
                            r_buf <= 32'd0;
                            if (bus.mem_req_in) begin
                                r_base  <= bus.mem_addr_in;
                                r_ram_a <= bus.mem_addr_in;
                                r_len   <= w_mem_len;
                                r_wdata <= bus.mem_wdata_in;
                                if (bus.mem_we_in) begin
                                    r_state    <= ST_MEM_WR;
                                    r_ram_dout <= bus.mem_wdata_in[7:0];
                                    r_wstrobe  <= 1'b1;
                                end else begin
                                    r_state <= ST_MEM_RD;
                                end
                            end else if (bus.if_req_in) begin
                                r_base  <= bus.if_addr_in;
                                r_ram_a <= bus.if_addr_in;
                                r_len   <= 3'd4;
                                r_state <= ST_IF_RD;
                            end
                        end
                    end
                    ST_IF_RD: begin
                        if (!bus.if_req_in) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_buf <= w_buf_next;
                            r_cnt <= w_next_cnt;
                            if (w_last) begin
                                r_if_inst <= w_buf_next;
                                r_if_done <= 1'b1;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_ram_a <= w_next_a;
                            end
                        end
                    end
                    ST_MEM_RD: begin
                        r_buf <= w_buf_next;
                        r_cnt <= w_next_cnt;
                        if (w_last) begin
                            r_mem_rdata <= w_buf_next;
                            r_mem_done  <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_ram_a <= w_next_a;
                        end
                    end
                    ST_MEM_WR: begin
                        r_cnt <= w_next_cnt;
                        if (w_last) begin
                            r_wstrobe  <= 1'b0;
                            r_mem_done <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_ram_a    <= w_next_a;
                            r_ram_dout <= w_wr_byte;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ram_a_out     = r_ram_a;
    assign bus.ram_dout_out  = r_ram_dout;
    assign bus.ram_wr_out    = r_wstrobe & bus.rdy_in;
    assign bus.if_done_out   = r_if_done;
    assign bus.if_inst_out   = r_if_inst;
    assign bus.mem_done_out  = r_mem_done;
    assign bus.mem_rdata_out = r_mem_rdata;
endmodule
`default_nettype wire
